// File: rtl/converter_bits_rx_pkg.sv
// Shared phy definitions: idle/alignment symbol, default lock depth and the
// receive-side state encoding used by phy_rx blocks.
package converter_bits_rx_pkg;

   localparam logic [7:0]  COMMA_DEF      = 8'hBC;
   localparam int unsigned LOCK_COUNT_DEF = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      LOCKED = 2'd2
   } rx_state_e;

endpackage

// File: rtl/converter_bits_rx.sv
// Serial-to-parallel receiver: hunts for the COM symbol bit by bit, confirms
// byte alignment over LOCK_COUNT symbols, then emits one byte per 8 dclk.
module converter_bits_rx
   import converter_bits_rx_pkg::*;
#(
   parameter logic [7:0]  COMMA      = COMMA_DEF,
   parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
   input  logic       dclk,
   input  logic       reset_L,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

   rx_state_e  state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] com_cnt_q, com_cnt_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       active_q, active_d;

   logic [7:0] next_sr;
   logic       boundary;
   logic       is_comma;

   // All decisions use the shift register including the bit sampled this
   // cycle, so a byte is recognised on the edge that samples its LSB.
   always_comb begin
      next_sr   = {sr_q[6:0], data_in};
      boundary  = (bit_cnt_q == 3'd7);
      is_comma  = (next_sr == COMMA);

      state_d   = state_q;
      sr_d      = next_sr;
      bit_cnt_d = bit_cnt_q;
      com_cnt_d = com_cnt_q;
      data_d    = data_q;
      valid_d   = 1'b0;

      case (state_q)
         SEARCH: begin
            if (is_comma) begin
               bit_cnt_d = 3'd0;
               com_cnt_d = 4'd1;
               state_d   = (LOCK_CNT4 == 4'd1) ? LOCKED : ALIGN;
            end
         end
         ALIGN: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (boundary) begin
               if (is_comma) begin
                  com_cnt_d = com_cnt_q + 4'd1;
                  if (com_cnt_q + 4'd1 == LOCK_CNT4) begin
                     state_d = LOCKED;
                  end
               end else begin
                  com_cnt_d = 4'd0;
                  state_d   = SEARCH;
               end
            end
         end
         LOCKED: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (boundary) begin
               data_d  = next_sr;
               valid_d = !is_comma;
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase

      active_d = (state_d == LOCKED);
   end

   always_ff @(posedge dclk) begin
      if (!reset_L) begin
         state_q   <= SEARCH;
         sr_q      <= 8'h00;
         bit_cnt_q <= 3'd0;
         com_cnt_q <= 4'd0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         active_q  <= active_d;
      end
   end

   // valid_out is a one-cycle qualifier with no back-pressure: data_out is
   // a new non-COM byte exactly in the cycle valid_out is high.
   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active    = active_q;

endmodule
